// File: rtl/i2c_apb_sequencer_if.sv
// Client request/response and APB master signals of the I2C APB sequencer.
interface i2c_apb_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic [7:0] cfg_prescale;
  logic       done;
  logic       err_nack;
  logic       err_timeout;
  logic [7:0] rdata;
  logic       PSELx;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;

  // Sequencer side: serves the client, masters the APB bus.
  modport master (
    input  req_valid, req_rw, req_addr, req_data, cfg_prescale, PRDATA, PREADY,
    output req_ready, done, err_nack, err_timeout, rdata,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  // Environment side: client plus APB register block.
  modport slave (
    output req_valid, req_rw, req_addr, req_data, cfg_prescale, PRDATA, PREADY,
    input  req_ready, done, err_nack, err_timeout, rdata,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/i2c_apb_sequencer.sv
// APB master turning single-byte I2C requests into the I2C register access sequence.
module i2c_apb_sequencer #(
  parameter int unsigned POLL_LIMIT = 255
) (
  input logic                 PCLK,
  input logic                 PRESETn,
  i2c_apb_sequencer_if.master bus
);

  localparam logic [7:0] A_PRESC  = 8'h20;
  localparam logic [7:0] A_ADDR   = 8'h40;
  localparam logic [7:0] A_STATUS = 8'h60;
  localparam logic [7:0] A_TX     = 8'h80;
  localparam logic [7:0] A_RX     = 8'hA0;
  localparam logic [7:0] A_CMD    = 8'hC0;
  localparam logic [7:0] LAST_POLL = 8'(POLL_LIMIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRESC, S_ADDR, S_POLL_TX, S_TXDATA,
    S_CMD, S_POLL_DONE, S_RXDATA, S_DONE
  } state_t;

  typedef enum logic [1:0] {P_SETUP, P_ACCESS, P_GAP} phase_t;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } xfer_t;

  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] presc_q, presc_d;
  logic       presc_wr_q, presc_wr_d;
  logic [7:0] last_presc_q, last_presc_d;
  logic [7:0] poll_cnt_q, poll_cnt_d;
  xfer_t      xfer_q, xfer_d;
  logic [7:0] rdata_q, rdata_d;
  logic       nack_q, nack_d;
  logic       tmo_q, tmo_d;
  logic       load_x;

  logic st_nack, st_busy, st_rxempty, st_txfull;
  assign st_nack    = bus.PRDATA[3];
  assign st_busy    = bus.PRDATA[2];
  assign st_rxempty = bus.PRDATA[1];
  assign st_txfull  = bus.PRDATA[0];

  // Address, data and direction of the transfer issued in a given main state.
  function automatic xfer_t xfer_of(input state_t s, input logic rw,
                                    input logic [7:0] a, input logic [7:0] d,
                                    input logic [7:0] p);
    xfer_t x;
    x = '0;
    case (s)
      S_PRESC:     begin x.wr = 1'b1; x.addr = A_PRESC; x.wdata = p; end
      S_ADDR:      begin x.wr = 1'b1; x.addr = A_ADDR;  x.wdata = a; end
      S_POLL_TX,
      S_POLL_DONE: x.addr = A_STATUS;
      S_TXDATA:    begin x.wr = 1'b1; x.addr = A_TX;    x.wdata = d; end
      S_CMD:       begin x.wr = 1'b1; x.addr = A_CMD;   x.wdata = rw ? 8'hC0 : 8'h80; end
      S_RXDATA:    x.addr = A_RX;
      default:     x = '0;
    endcase
    return x;
  endfunction

  // State and datapath registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= S_IDLE;
      phase_q      <= P_SETUP;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      presc_q      <= '0;
      presc_wr_q   <= 1'b0;
      last_presc_q <= '0;
      poll_cnt_q   <= '0;
      xfer_q       <= '0;
      rdata_q      <= '0;
      nack_q       <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      presc_q      <= presc_d;
      presc_wr_q   <= presc_wr_d;
      last_presc_q <= last_presc_d;
      poll_cnt_q   <= poll_cnt_d;
      xfer_q       <= xfer_d;
      rdata_q      <= rdata_d;
      nack_q       <= nack_d;
      tmo_q        <= tmo_d;
    end
  end

  // Next-state logic. The next main state is chosen when ACCESS completes so
  // the following GAP cycle already belongs to it; this lets the last GAP be DONE.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    data_d       = data_q;
    presc_d      = presc_q;
    presc_wr_d   = presc_wr_q;
    last_presc_d = last_presc_q;
    poll_cnt_d   = poll_cnt_q;
    rdata_d      = rdata_q;
    nack_d       = nack_q;
    tmo_d        = tmo_q;
    load_x       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          rw_d    = bus.req_rw;
          addr_d  = bus.req_addr;
          data_d  = bus.req_data;
          presc_d = bus.cfg_prescale;
          nack_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = (!presc_wr_q || bus.cfg_prescale != last_presc_q) ? S_PRESC : S_ADDR;
          phase_d = P_SETUP;
          load_x  = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        case (phase_q)
          P_SETUP: phase_d = P_ACCESS;
          P_ACCESS: begin
            if (bus.PREADY) begin
              phase_d    = P_GAP;
              poll_cnt_d = '0;
              case (state_q)
                S_PRESC: begin
                  state_d      = S_ADDR;
                  presc_wr_d   = 1'b1;
                  last_presc_d = presc_q;
                end
                S_ADDR: state_d = S_POLL_TX;
                S_POLL_TX: begin
                  if (!st_busy && (rw_q || !st_txfull)) begin
                    state_d = rw_q ? S_CMD : S_TXDATA;
                  end else if (poll_cnt_q == LAST_POLL) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                  end else begin
                    poll_cnt_d = poll_cnt_q + 8'd1;
                  end
                end
                S_TXDATA: state_d = S_CMD;
                S_CMD:    state_d = S_POLL_DONE;
                S_POLL_DONE: begin
                  nack_d = st_nack;
                  if (!st_busy && (!rw_q || !st_rxempty || st_nack)) begin
                    state_d = (rw_q && !st_nack) ? S_RXDATA : S_DONE;
                  end else if (poll_cnt_q == LAST_POLL) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                  end else begin
                    poll_cnt_d = poll_cnt_q + 8'd1;
                  end
                end
                S_RXDATA: begin
                  rdata_d = bus.PRDATA;
                  state_d = S_DONE;
                end
                default: ;
              endcase
            end
          end
          default: begin
            phase_d = P_SETUP;
            load_x  = 1'b1;
          end
        endcase
      end
    endcase
    // At acceptance the request fields are not yet latched, so use the live inputs.
    if (load_x) begin
      if (state_q == S_IDLE) begin
        xfer_d = xfer_of(state_d, bus.req_rw, bus.req_addr, bus.req_data, bus.cfg_prescale);
      end else begin
        xfer_d = xfer_of(state_d, rw_q, addr_q, data_q, presc_q);
      end
    end else begin
      xfer_d = xfer_q;
    end
  end

  // Outputs; select/enable decode from reset-cleared state so they drop asynchronously.
  always_comb begin
    bus.req_ready   = (state_q == S_IDLE);
    bus.done        = (state_q == S_DONE);
    bus.err_nack    = (state_q == S_DONE) && nack_q;
    bus.err_timeout = (state_q == S_DONE) && tmo_q;
    bus.rdata       = rdata_q;
    bus.PSELx       = 1'b0;
    bus.PENABLE     = 1'b0;
    if (state_q != S_IDLE && state_q != S_DONE) begin
      bus.PSELx   = (phase_q == P_SETUP) || (phase_q == P_ACCESS);
      bus.PENABLE = (phase_q == P_ACCESS);
    end
    bus.PWRITE = xfer_q.wr;
    bus.PADDR  = xfer_q.addr;
    bus.PWDATA = xfer_q.wdata;
  end

endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// Randomized self-checking bench: an APB slave model replays transactions
// predicted by a request-level reference model of the I2C register sequence.
module tb_i2c_apb_sequencer;

  localparam int unsigned PL = 4;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;

  i2c_apb_sequencer_if bus();

  i2c_apb_sequencer #(.POLL_LIMIT(PL)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus.master)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0]  addr;
    logic        wr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int unsigned waits;
  } xact_t;

  xact_t       exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // reference model state
  bit          m_pw = 1'b0;
  logic [7:0]  m_last = '0;
  logic [7:0]  m_rdata = '0;
  bit          m_nack, m_tmo;
  int unsigned m_cycles;

  // stimulus scripts (negative default = random)
  logic [7:0]  st_script[$];
  int unsigned w_script[$];
  int          st_default = 0;
  int          w_default  = 0;
  int          rx_fixed   = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] next_status();
    if (st_script.size() > 0) return st_script.pop_front();
    if (st_default >= 0) return 8'(st_default);
    if ($urandom_range(0, 2) == 0) return 8'($urandom);
    return 8'($urandom) & 8'hF0;
  endfunction

  function automatic int unsigned next_wait();
    if (w_script.size() > 0) return w_script.pop_front();
    if (w_default >= 0) return int'(w_default);
    return ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
  endfunction

  function automatic void push(input logic [7:0] a, input logic wr,
                               input logic [7:0] wd, input logic [7:0] rd);
    xact_t x;
    x.addr = a; x.wr = wr; x.wdata = wd; x.rdata = rd; x.waits = next_wait();
    exp_q.push_back(x);
    m_cycles += 3 + x.waits;
  endfunction

  // Predicts the full register-access list, latency and result of one request.
  function automatic void model_req(input logic rw, input logic [7:0] a,
                                    input logic [7:0] d, input logic [7:0] p);
    logic [7:0] s, r;
    bit ok;
    m_cycles = 0; m_nack = 0; m_tmo = 0;
    if (!m_pw || p != m_last) begin
      push(8'h20, 1'b1, p, 8'h00);
      m_pw = 1'b1; m_last = p;
    end
    push(8'h40, 1'b1, a, 8'h00);
    ok = 0;
    for (int n = 0; n < int'(PL) && !ok; n++) begin
      s = next_status();
      push(8'h60, 1'b0, 8'h00, s);
      ok = !s[2] && (rw || !s[0]);
    end
    if (!ok) begin m_tmo = 1; return; end
    if (!rw) push(8'h80, 1'b1, d, 8'h00);
    push(8'hC0, 1'b1, rw ? 8'hC0 : 8'h80, 8'h00);
    ok = 0;
    for (int n = 0; n < int'(PL) && !ok; n++) begin
      s = next_status();
      push(8'h60, 1'b0, 8'h00, s);
      ok = !s[2] && (!rw || !s[1] || s[3]);
      m_nack = s[3];
    end
    if (!ok) begin m_tmo = 1; return; end
    if (rw && !m_nack) begin
      r = (rx_fixed >= 0) ? 8'(rx_fixed) : 8'($urandom);
      push(8'hA0, 1'b0, 8'h00, r);
      m_rdata = r;
    end
  endfunction

  // APB slave: checks each transfer against the predicted list and inserts waits.
  logic [7:0]  s_addr, s_wdata;
  logic        s_wr;
  bit          in_acc;
  int unsigned acc_n;
  xact_t       cur;

  initial begin
    bus.PREADY = 1'b0;
    bus.PRDATA = '0;
    in_acc = 0;
    acc_n  = 0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        in_acc = 0;
        bus.PREADY = 1'b0;
      end else if (bus.PSELx && bus.PENABLE) begin
        acc_n++;
        check("acc_stable", {15'd0, bus.PADDR, bus.PWDATA, bus.PWRITE},
              {15'd0, s_addr, s_wdata, s_wr});
        bus.PREADY = (acc_n == cur.waits + 1);
      end else begin
        if (in_acc) begin
          check("acc_len", acc_n, cur.waits + 1);
          in_acc = 0;
        end
        bus.PREADY = 1'b0;
        if (bus.PSELx) begin
          check("xfer_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          else begin
            cur.addr = 8'hFF; cur.wr = 1'b0; cur.wdata = '0; cur.rdata = '0; cur.waits = 0;
          end
          check("paddr", bus.PADDR, cur.addr);
          check("pwrite", bus.PWRITE, cur.wr);
          if (cur.wr) check("pwdata", bus.PWDATA, cur.wdata);
          s_addr = bus.PADDR; s_wdata = bus.PWDATA; s_wr = bus.PWRITE;
          bus.PRDATA = cur.rdata;
          acc_n  = 0;
          in_acc = 1;
        end
      end
    end
  end

  // Issues one request and checks latency and completion outputs; returns at the DONE negedge.
  task automatic run_req(input logic rw, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] p, input string nm);
    int unsigned k;
    model_req(rw, a, d, p);
    bus.req_rw = rw; bus.req_addr = a; bus.req_data = d; bus.cfg_prescale = p;
    bus.req_valid = 1'b1;
    if (bus.done) begin
      check("ready_in_done", bus.req_ready, 0);
      @(negedge PCLK);
      check("done_pulse", bus.done, 0);
      check("nack_pulse", bus.err_nack, 0);
      check("tmo_pulse", bus.err_timeout, 0);
      check("no_accept_in_done", bus.PSELx, 0);
    end
    k = 0;
    while (!bus.req_ready && k < 50) begin @(negedge PCLK); k++; end
    check("ready_wait", bus.req_ready, 1);
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    k = 1;
    while (!bus.done && k < 2000) begin @(negedge PCLK); k++; end
    check({nm, "_done_cycle"}, k, m_cycles);
    check({nm, "_err_nack"}, bus.err_nack, m_nack);
    check({nm, "_err_timeout"}, bus.err_timeout, m_tmo);
    check({nm, "_rdata"}, bus.rdata, m_rdata);
    check({nm, "_ready_low"}, bus.req_ready, 0);
    check({nm, "_xfers_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int unsigned k;
    logic [7:0] p;
    bit saw_done;
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0;
    bus.req_data = '0; bus.cfg_prescale = '0;
    repeat (3) @(negedge PCLK);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_err_nack", bus.err_nack, 0);
    check("rst_err_timeout", bus.err_timeout, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_psel", bus.PSELx, 0);
    check("rst_penable", bus.PENABLE, 0);
    check("rst_pwrite", bus.PWRITE, 0);
    check("rst_paddr", bus.PADDR, 0);
    check("rst_pwdata", bus.PWDATA, 0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // directed cases
    run_req(1'b0, 8'h01, 8'h05, 8'd4, "wr_first");
    check("wr_first_latency", m_cycles, 18);
    run_req(1'b0, 8'h01, 8'h05, 8'd4, "wr_again");
    check("wr_again_latency", m_cycles, 15);
    run_req(1'b0, 8'h01, 8'h05, 8'd8, "wr_newpresc");
    st_script = '{8'h04, 8'h04};
    rx_fixed  = 8'h02;
    run_req(1'b1, 8'h33, 8'h00, 8'd8, "rd_poll");
    check("rd_poll_rdata_abs", bus.rdata, 8'h02);
    st_default = 8'h04;
    run_req(1'b0, 8'h44, 8'h99, 8'd8, "tx_timeout");
    st_default = 0;
    st_script = '{8'h08, 8'h08};
    run_req(1'b1, 8'h55, 8'h00, 8'd8, "rd_nack");
    check("rd_nack_rdata_kept", bus.rdata, 8'h02);
    w_script = '{0, 3};
    run_req(1'b0, 8'h5A, 8'hA5, 8'd8, "wait3");

    // reset in the middle of a request
    model_req(1'b0, 8'h12, 8'h34, 8'd8);
    bus.req_rw = 1'b0; bus.req_addr = 8'h12; bus.req_data = 8'h34; bus.cfg_prescale = 8'd8;
    @(negedge PCLK);
    bus.req_valid = 1'b1;
    k = 0;
    while (!bus.req_ready && k < 50) begin @(negedge PCLK); k++; end
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge PCLK);
    k = 0;
    while (!bus.PSELx && k < 20) begin @(negedge PCLK); k++; end
    check("abort_psel_before", bus.PSELx, 1);
    #2 PRESETn = 1'b0;
    #1;
    check("abort_psel_async", bus.PSELx, 0);
    check("abort_penable_async", bus.PENABLE, 0);
    exp_q.delete();
    m_pw = 1'b0;
    m_rdata = '0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    saw_done = 0;
    repeat (20) begin
      @(negedge PCLK);
      if (bus.done) saw_done = 1;
    end
    check("abort_no_done", saw_done, 0);
    run_req(1'b0, 8'h12, 8'h34, 8'd8, "after_abort");
    check("after_abort_latency", m_cycles, 18);

    // randomized requests
    st_default = -1;
    w_default  = -1;
    rx_fixed   = -1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) p = 8'($urandom);
      else p = $urandom_range(0, 1) ? 8'd4 : 8'd8;
      run_req(1'($urandom), 8'($urandom), 8'($urandom), p, "rand");
    end

    @(negedge PCLK);
    check("final_done_low", bus.done, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_apb_sequencer.md
# i2c_apb_sequencer

APB master that turns single-byte I2C transfer requests into the register access sequence the I2C APB slave expects. It configures the prescaler, loads the slave address and transmit byte, polls status, issues the command, and collects received data. It sits between a simple request/response client and the `apb` register block, which it drives as that block's only APB master.

## Interface
- `POLL_LIMIT`, default 255: maximum STATUS reads per poll phase before timeout (1..255).
- `PCLK  in  1`: clock.
- `PRESETn  in  1`: asynchronous active-low reset.
- `req_valid  in  1`: client request strobe.
- `req_ready  out  1`: high only in IDLE.
- `req_rw  in  1`: 0 = write byte, 1 = read byte.
- `req_addr  in  8`: value written to the ADDRESS register.
- `req_data  in  8`: byte written to the TRANSMIT register (ignored for reads).
- `cfg_prescale  in  8`: prescaler value.
- `done  out  1`: one-cycle completion pulse.
- `err_nack  out  1`: valid with `done`; STATUS[3] was set at the final poll.
- `err_timeout  out  1`: valid with `done`; a poll exceeded `POLL_LIMIT`.
- `rdata  out  8`: last RECEIVE value; held until the next successful read.
- `PSELx  out  1`, `PENABLE  out  1`, `PWRITE  out  1`, `PADDR  out  8`, `PWDATA  out  8`: APB master outputs.
- `PRDATA  in  8`, `PREADY  in  1`: APB slave responses.

## Operation
- Register map (PADDR):
  - PRESCALE 0x20 (write)
  - ADDRESS 0x40 (write)
  - STATUS 0x60 (read)
  - TRANSMIT 0x80 (write)
  - RECEIVE 0xA0 (read)
  - COMMAND 0xC0 (write)
- STATUS bits, all active-high: [3] nack, [2] busy, [1] rx_empty, [0] tx_full.
- COMMAND value: 0x80 for a write, 0xC0 for a read (bit7 = start, bit6 = read).
- Request acceptance: a request is accepted on the edge where `req_valid && req_ready`. The block latches `req_rw`, `req_addr`, `req_data` and `cfg_prescale`.
- Main FSM: IDLE -> [PRESC] -> ADDR -> POLL_TX -> [TXDATA] -> CMD -> POLL_DONE -> [RXDATA] -> DONE -> IDLE.
- PRESC: entered only if the prescaler has not been written since reset, or if the latched `cfg_prescale` differs from the last value written.
- POLL_TX: repeats STATUS reads until busy=0, and additionally tx_full=0 for writes.
- TXDATA: write requests only.
- POLL_DONE: repeats STATUS reads until busy=0; for reads, also until rx_empty=0 unless nack=1.
- nack handling: nack=1 at POLL_DONE exit skips RXDATA and reports `err_nack`. nack seen in POLL_TX is ignored, because it is stale.
- Poll timeout: the poll counter resets on entry to each poll phase. If the `POLL_LIMIT`-th read still fails its exit condition, the FSM goes to DONE with `err_timeout`=1, skipping the remaining steps and sending no COMMAND if the timeout occurred in POLL_TX.
- RXDATA: `rdata` is loaded from PRDATA at ACCESS completion.
- APB sub-FSM per transfer:
  - SETUP: PSELx=1, PENABLE=0, address/data/write stable.
  - ACCESS: PENABLE=1, held while PREADY=0.
  - GAP: PSELx=0, PENABLE=0, one cycle.
- PADDR, PWDATA and PWRITE hold their values through the GAP cycle.
- Reset values: `req_ready`=1, `done`=0, `err_*`=0, `rdata`=0x00, all APB outputs 0, prescaler-written flag cleared.
- Reset mid-transfer: PSELx and PENABLE drop asynchronously. No `done` is produced for the aborted request, and the next request rewrites PRESCALE.

## Timing
- First SETUP occurs in the cycle after acceptance.
- Each transfer takes 3 cycles plus the number of PREADY=0 wait cycles in ACCESS.
- The final transfer's GAP cycle is the DONE state: `done`=1, `req_ready`=0, and `err_*` are valid in that same cycle. IDLE with `req_ready`=1 follows.
- Write latency, prescaler already written, PREADY=1, each poll passes first time: 5 transfers; `done` at cycle 15 after acceptance. Add 3 cycles if PRESCALE is written.
- Read latency under the same conditions: 5 transfers (no TXDATA, adds RXDATA); `done` at cycle 15.
- `req_valid` asserted during DONE is not accepted; acceptance occurs no earlier than the following cycle.
- `done`, `err_nack` and `err_timeout` are each exactly one cycle wide.

## Test plan
- After reset, write request (addr 0x01, data 0x05, prescale 4), STATUS=0x00, PREADY=1 -> APB write sequence:
  - 0x20←0x04, 0x40←0x01, read 0x60, 0x80←0x05, 0xC0←0x80, read 0x60
  - `done` at cycle 18, no errors.
- Second identical write -> no PRESCALE access, `done` at cycle 15. Changing `cfg_prescale` to 8 -> 0x20←0x08 reappears.
- Read request, STATUS returns 0x04 twice then 0x00, PRDATA at 0xA0 = 0x02 -> COMMAND 0xC0, two extra polls, `rdata`=0x02, `done` with no errors.
- STATUS stuck at 0x04 with `POLL_LIMIT`=4 -> exactly 4 STATUS reads in POLL_TX, no COMMAND write, `done`+`err_timeout`.
- STATUS=0x08 at POLL_DONE on a read -> no RECEIVE access, `rdata` unchanged, `done`+`err_nack`.
- PREADY held low 3 cycles in an ACCESS -> PENABLE stays high 4 cycles, with PSELx, PENABLE, PADDR and PWDATA stable. PRESETn pulsed low mid-sequence -> PSELx=0 immediately, no `done`, next request rewrites PRESCALE.
